// File: rtl/shift_add_multiplier_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shift_add_multiplier_pkg
// Brief    : Shared constants and state encoding for the shift-add
//            multiply-accumulate unit (p = a*b + c).
// Revision : 1.0 - initial release
// ============================================================================
package shift_add_multiplier_pkg;

    localparam int OPERAND_W  = 10;
    localparam int PRODUCT_W  = 2 * OPERAND_W;
    localparam int ITERATIONS = OPERAND_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_ADD  = 2'b10,
        ST_DONE = 2'b11
    } state_t;

endpackage
`default_nettype wire

// File: rtl/shift_add_multiplier_iter_counter.sv
`default_nettype none
// ============================================================================
// Module   : iter_counter
// Brief    : Iteration counter for the shift-add loop. Synchronous clear,
//            increment enable, terminal-count flag when the count is N-1.
// Revision : 1.0 - initial release
// ============================================================================
module iter_counter #(
    parameter int N = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic inc,
    output logic tc
);

    localparam int CNT_W = $clog2(N + 1);

    logic [CNT_W-1:0] r_cnt;

    // Count CALC iterations; clear has priority over increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (inc) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign tc = (r_cnt == CNT_W'(N - 1));

endmodule
`default_nettype wire

// File: rtl/shift_add_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : shift_add_multiplier
// Brief    : Sequential unsigned multiply-accumulate p = a*b + c, one
//            add-and-shift-right iteration per clock, start/busy/done
//            handshake. Inverse of the restoring divider datapath.
// Revision : 1.0 - initial release
// ============================================================================
module shift_add_multiplier
    import shift_add_multiplier_pkg::*;
#(
    parameter int N = OPERAND_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           sclr,
    input  logic           start,
    input  logic [N-1:0]   a_in,
    input  logic [N-1:0]   b_in,
    input  logic [N-1:0]   c_in,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] p_out
);

    state_t           r_state;
    state_t           w_next;
    logic             w_load;
    logic             w_tc;
    logic [N-1:0]     r_b;
    logic [N-1:0]     r_c;
    logic [N-1:0]     r_q;
    logic [N:0]       r_acc;
    logic [N:0]       w_sum;
    logic [2*N-1:0]   r_p;

    // A new operation is accepted only from IDLE or DONE, and sclr wins
    assign w_load = start && !sclr && ((r_state == ST_IDLE) || (r_state == ST_DONE));

    // r_acc[N] is always zero after a shift, so this equals ACC[N-1:0] + addend
    assign w_sum = r_acc + {1'b0, (r_q[0] ? r_b : {N{1'b0}})};

    iter_counter #(
        .N (N)
    ) u_iter_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (sclr || w_load),
        .inc   (r_state == ST_CALC),
        .tc    (w_tc)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and Moore outputs
    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_load) w_next = ST_CALC;
            end
            ST_CALC: begin
                busy = 1'b1;
                if (w_tc) w_next = ST_ADD;
            end
            ST_ADD: begin
                busy   = 1'b1;
                w_next = ST_DONE;
            end
            ST_DONE: begin
                done   = 1'b1;
                w_next = w_load ? ST_CALC : ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
        if (sclr) w_next = ST_IDLE;
    end

    // Datapath: operand load, add-and-shift iterations, final addend
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_b   <= '0;
            r_c   <= '0;
            r_q   <= '0;
            r_acc <= '0;
            r_p   <= '0;
        end else if (sclr) begin
            r_b   <= '0;
            r_c   <= '0;
            r_q   <= '0;
            r_acc <= '0;
            r_p   <= '0;
        end else if (w_load) begin
            r_b   <= b_in;
            r_c   <= c_in;
            r_q   <= a_in;
            r_acc <= '0;
        end else if (r_state == ST_CALC) begin
            r_acc <= {1'b0, w_sum[N:1]};
            r_q   <= {w_sum[0], r_q[N-1:1]};
        end else if (r_state == ST_ADD) begin
            r_p   <= {r_acc[N-1:0], r_q} + {{N{1'b0}}, r_c};
        end
    end

    assign p_out = r_p;

endmodule
`default_nettype wire

// File: tb/tb_shift_add_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_add_multiplier
// Brief    : Self-checking bench for shift_add_multiplier; expected results
//            come from plain integer arithmetic a*b + c.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_add_multiplier;

    localparam int N = 10;

    logic           clk;
    logic           rst_n;
    logic           sclr;
    logic           start;
    logic [N-1:0]   a_in;
    logic [N-1:0]   b_in;
    logic [N-1:0]   c_in;
    logic           busy;
    logic           done;
    logic [2*N-1:0] p_out;

    int tests_run;
    int tests_failed;

    shift_add_multiplier #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sclr  (sclr),
        .start (start),
        .a_in  (a_in),
        .b_in  (b_in),
        .c_in  (c_in),
        .busy  (busy),
        .done  (done),
        .p_out (p_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] model(input logic [N-1:0] a, b, c);
        longint r;
        r = longint'(a) * longint'(b) + longint'(c);
        return r[31:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble();
        a_in = N'($urandom);
        b_in = N'($urandom);
        c_in = N'($urandom);
    endtask

    // Drive operands with start; returns just after the accept edge E
    task automatic issue(input logic [N-1:0] a, b, c);
        a_in  = a;
        b_in  = b;
        c_in  = c;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Follow one operation from just after E to the DONE cycle. With noise,
    // start toggles during CALC/ADD with garbage operands. With chain, start
    // stays high and the next operands are presented in DONE.
    task automatic follow(input logic [31:0] exp, input bit noise, input bit chain,
                          input logic [N-1:0] na, nb, nc);
        for (int k = 0; k < 11; k++) begin
            check("busy_calc", 32'(busy), 32'd1);
            check("done_calc", 32'(done), 32'd0);
            if (noise) begin
                start = 1'($urandom);
                scramble();
            end
            if (chain) start = 1'b1;
            step();
        end
        if (chain) begin
            a_in  = na;
            b_in  = nb;
            c_in  = nc;
            start = 1'b1;
        end else begin
            start = 1'b0;
        end
        check("done_pulse", 32'(done), 32'd1);
        check("busy_done", 32'(busy), 32'd0);
        check("p_out", 32'(p_out), exp);
        step();
        start = 1'b0;
        check("done_after", 32'(done), 32'd0);
        if (!chain) check("p_hold", 32'(p_out), exp);
    endtask

    task automatic run_op(input logic [N-1:0] a, b, c, input bit noise);
        issue(a, b, c);
        follow(model(a, b, c), noise, 1'b0, '0, '0, '0);
    endtask

    initial begin
        logic [N-1:0] ra, rb, rc;
        logic [31:0]  last;
        tests_run    = 0;
        tests_failed = 0;
        sclr  = 1'b0;
        start = 1'b0;
        rst_n = 1'b0;
        a_in  = '0;
        b_in  = '0;
        c_in  = '0;

        // Reset state before any clock edge, with inputs toggling
        #1;
        scramble();
        start = 1'b1;
        #1;
        check("rst_p", 32'(p_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        start = 1'b0;
        step();
        rst_n = 1'b1;
        step();

        // Basic product and hold over idle cycles
        run_op(10'd37, 10'd27, 10'd0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            scramble();
            step();
            check("hold_999", 32'(p_out), 32'd999);
            check("idle_busy", 32'(busy), 32'd0);
        end

        // Boundaries and divider round-trips
        run_op(10'd1023, 10'd1023, 10'd1023, 1'b0);
        check("max_value", 32'(p_out), 32'd1047552);
        run_op(10'd0,   10'd500, 10'd7, 1'b0);
        run_op(10'd500, 10'd0,   10'd0, 1'b0);
        run_op(10'd142, 10'd7,   10'd6, 1'b0);
        check("div_rt_1000", 32'(p_out), 32'd1000);
        run_op(10'd1023, 10'd1, 10'd0, 1'b0);

        // Start pulses during CALC/ADD are ignored
        run_op(10'd321, 10'd654, 10'd99, 1'b1);

        // Start held high through DONE: back-to-back operation
        issue(10'd11, 10'd13, 10'd5);
        follow(model(10'd11, 10'd13, 10'd5), 1'b0, 1'b1, 10'd600, 10'd700, 10'd800);
        follow(model(10'd600, 10'd700, 10'd800), 1'b0, 1'b0, '0, '0, '0);

        // Async reset mid-operation
        issue(10'd77, 10'd88, 10'd9);
        for (int k = 0; k < 5; k++) step();
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_p", 32'(p_out), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            check("post_rst_done", 32'(done), 32'd0);
            check("post_rst_busy", 32'(busy), 32'd0);
        end
        run_op(10'd77, 10'd88, 10'd9, 1'b0);

        // Synchronous clear mid-operation, start asserted at the same edge
        issue(10'd200, 10'd300, 10'd400);
        for (int k = 0; k < 4; k++) step();
        sclr  = 1'b1;
        start = 1'b1;
        scramble();
        step();
        sclr  = 1'b0;
        start = 1'b0;
        check("sclr_busy", 32'(busy), 32'd0);
        check("sclr_p", 32'(p_out), 32'd0);
        check("sclr_done", 32'(done), 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            check("post_sclr_busy", 32'(busy), 32'd0);
        end

        // sclr beats start while idle
        sclr  = 1'b1;
        start = 1'b1;
        step();
        sclr  = 1'b0;
        start = 1'b0;
        check("sclr_vs_start", 32'(busy), 32'd0);
        step();
        check("sclr_vs_start2", 32'(busy), 32'd0);

        // Randomized operations, some with start noise
        last = 32'd0;
        for (int i = 0; i < 30; i++) begin
            ra = N'($urandom);
            rb = N'($urandom);
            rc = N'($urandom);
            if (i % 5 == 0) ra = '0;
            run_op(ra, rb, rc, 1'($urandom));
            last = model(ra, rb, rc);
        end
        step();
        check("rand_final_hold", 32'(p_out), last);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
